// File: rtl/wb_mon_pkg.sv
// Shared types and helpers for the Wishbone classic-cycle monitor.
// Flag indices double as bit positions in err_flags_o.
package wb_mon_pkg;

  typedef enum logic [1:0] {
    POST_RST,
    IDLE,
    WAIT,
    TOUT
  } state_t;

  localparam int E_RST_ACT    = 0;
  localparam int E_STB_NO_CYC = 1;
  localparam int E_ACK_SPUR   = 2;
  localparam int E_UNSTABLE   = 3;
  localparam int E_TIMEOUT    = 4;
  localparam int E_ACK_ERR    = 5;
  localparam int N_ERR        = 6;

  // Lowest set index plus one, zero when nothing is set.
  function automatic logic [2:0] first_set(
    input logic [N_ERR-1:0] f
  );
    first_set = 3'd0;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      if (f[i]) first_set = 3'(i + 1);
    end
  endfunction

endpackage

// File: rtl/wb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear together with inc loads one, so no event is lost.
module wb_mon_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? ONE : '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/wb_bus_monitor.sv
// Passive Wishbone classic-cycle protocol monitor: sticky error
// flags, first-error code, transfer counters and worst ack latency.
module wb_bus_monitor
  import wb_mon_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16,
  parameter int LAT_W       = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic              wb_ack_o,
  input  logic              wb_err_o,
  input  logic              clr_i,
  output logic [N_ERR-1:0]  err_flags_o,
  output logic [2:0]        err_first_o,
  output logic              err_irq_o,
  output logic [CNT_W-1:0]  wr_cnt_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [LAT_W-1:0]  max_lat_o
);

  localparam int SW = DW / 8;
  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_TO  = LAT_W'(ACK_TIMEOUT - 1);

  state_t            state;
  logic [AW-1:0]     adr_q;
  logic              we_q;
  logic [SW-1:0]     sel_q;
  logic [LAT_W-1:0]  lat;

  logic              req, done, idle_like, busy, start;
  logic              ack_done, we_eff, timeout_hit, unstable;
  logic [LAT_W-1:0]  cur_lat;
  logic [N_ERR-1:0]  viol, flag_base;
  logic [2:0]        first_base;

  assign req       = wb_cyc_i & wb_stb_i;
  assign done      = wb_ack_o | wb_err_o;
  assign idle_like = (state == IDLE) || (state == POST_RST);
  assign busy      = (state == WAIT) || (state == TOUT);
  assign start     = idle_like & req;
  assign ack_done  = req & wb_ack_o;
  assign we_eff    = idle_like ? wb_we_i : we_q;
  assign cur_lat   = idle_like ? LAT_ONE : lat;

  // Timeout only counts while the master is still strobing.
  assign timeout_hit = (state == WAIT) && req && !done
                       && (lat >= LAT_TO);
  assign unstable    = busy && req
                       && (wb_adr_i != adr_q || wb_we_i != we_q
                           || wb_sel_i != sel_q);

  always_comb begin
    viol = '0;
    viol[E_RST_ACT]    = (state == POST_RST) && (wb_cyc_i || wb_stb_i);
    viol[E_STB_NO_CYC] = wb_stb_i && !wb_cyc_i;
    viol[E_ACK_SPUR]   = done && !req;
    viol[E_UNSTABLE]   = unstable;
    viol[E_TIMEOUT]    = timeout_hit;
    viol[E_ACK_ERR]    = wb_ack_o && wb_err_o;
  end

  assign flag_base  = clr_i ? '0 : err_flags_o;
  assign first_base = clr_i ? 3'd0 : err_first_o;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_flags_o <= '0;
      err_first_o <= 3'd0;
      err_irq_o   <= 1'b0;
      max_lat_o   <= '0;
    end else begin
      err_flags_o <= flag_base | viol;
      err_irq_o   <= |(viol & ~flag_base);
      err_first_o <= (first_base == 3'd0) ? first_set(viol) : first_base;
      if (clr_i) begin
        max_lat_o <= ack_done ? cur_lat : '0;
      end else if (ack_done && cur_lat > max_lat_o) begin
        max_lat_o <= cur_lat;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= POST_RST;
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      unique case (state)
        POST_RST, IDLE: begin
          if (req) begin
            adr_q <= wb_adr_i;
            we_q  <= wb_we_i;
            sel_q <= wb_sel_i;
          end
          state <= (req && !done) ? WAIT : IDLE;
        end
        WAIT: begin
          if (!req || done) state <= IDLE;
          else if (timeout_hit) state <= TOUT;
        end
        TOUT: begin
          if (!req || done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  wb_mon_sat_cnt #(.W(LAT_W)) u_lat (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (start),
    .inc (start | busy),
    .cnt (lat)
  );

  wb_mon_sat_cnt #(.W(CNT_W)) u_wr (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (clr_i),
    .inc (ack_done & we_eff),
    .cnt (wr_cnt_o)
  );

  wb_mon_sat_cnt #(.W(CNT_W)) u_rd (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (clr_i),
    .inc (ack_done & ~we_eff),
    .cnt (rd_cnt_o)
  );

endmodule
